gslcd: RTL and testbench

GSLCD -- requirements
Module: gslcd

---
 rtl/gslcd.sv | 261 ++++++++++++++++++++++++++
 tb/tb_gslcd.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gslcd.sv
// rtl/gslcd.sv - AXI-Lite controlled RGB888 LCD timing generator with AXI burst framebuffer fetch
module gslcd #(
  parameter int C_S00_AXI_ADDR_WIDTH = 4,
  parameter int C_M00_AXI_BURST_LEN  = 16,
  parameter int FIFO_DEPTH           = 32
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_areset,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0] s00_axi_awaddr,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [31:0]                     s00_axi_wdata,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0] s00_axi_araddr,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [31:0]                     s00_axi_rdata,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [31:0]                     m00_axi_araddr,
  output logic [7:0]                      m00_axi_arlen,
  output logic                            m00_axi_arvalid,
  input  logic                            m00_axi_arready,
  input  logic [31:0]                     m00_axi_rdata,
  input  logic                            m00_axi_rvalid,
  input  logic                            m00_axi_rlast,
  output logic                            m00_axi_rready,
  output logic                            LCD_DEN,
  output logic                            LCD_HSYNC,
  output logic                            LCD_VSYNC,
  output logic [23:0]                     LCD_DATA
);

  localparam int AW = C_S00_AXI_ADDR_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int FRAME_WORDS = 480 * 272;
  localparam int WW = $clog2(FRAME_WORDS + 1);

  localparam logic [AW-1:0] ADDR_CTRL   = AW'(0);
  localparam logic [AW-1:0] ADDR_FBADDR = AW'(4);
  localparam logic [AW-1:0] ADDR_STATUS = AW'(8);

  localparam logic [9:0] H_SYNC_END  = 10'd41;
  localparam logic [9:0] H_ACT_START = 10'd43;
  localparam logic [9:0] H_ACT_END   = 10'd523;
  localparam logic [9:0] H_LAST      = 10'd524;
  localparam logic [8:0] V_SYNC_END  = 9'd10;
  localparam logic [8:0] V_ACT_START = 9'd12;
  localparam logic [8:0] V_ACT_END   = 9'd284;
  localparam logic [8:0] V_LAST      = 9'd285;

  localparam logic [1:0] F_IDLE = 2'd0;
  localparam logic [1:0] F_AR   = 2'd1;
  localparam logic [1:0] F_RECV = 2'd2;

  logic          rst;
  logic          ready_en;
  logic          ctrl_en;
  logic          en_d;
  logic          en_rise;
  logic [31:0]   fbaddr;
  logic          underflow;
  logic          bvalid_r;
  logic          rvalid_r;
  logic [31:0]   rdata_r;
  logic [31:0]   rd_mux;
  logic          wr_fire;
  logic          rd_fire;

  logic [1:0]    div;
  logic          strobe;
  logic [9:0]    h;
  logic [8:0]    v;
  logic          active;
  logic          frame_end;

  logic [23:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          uf_set;

  logic [1:0]    state;
  logic [31:0]   ar_addr;
  logic [31:0]   fetch_addr;
  logic [WW-1:0] words;
  logic          beat;
  logic          issue;

  logic          unused_bits;

  assign rst = s00_axi_areset;
  assign unused_bits = ^{s00_axi_wdata[5:2], m00_axi_rdata[31:24]};

  // Ready is gated by a registered flag so every handshake output is low while in reset.
  assign wr_fire = ready_en && !bvalid_r && s00_axi_awvalid && s00_axi_wvalid;
  assign rd_fire = ready_en && !rvalid_r && s00_axi_arvalid;
  assign s00_axi_awready = wr_fire;
  assign s00_axi_wready  = wr_fire;
  assign s00_axi_arready = rd_fire;
  assign s00_axi_bvalid  = bvalid_r;
  assign s00_axi_rvalid  = rvalid_r;
  assign s00_axi_rdata   = rdata_r;

  always_comb begin
    rd_mux = 32'd0;
    case (s00_axi_araddr)
      ADDR_CTRL:   rd_mux = {31'd0, ctrl_en};
      ADDR_FBADDR: rd_mux = fbaddr;
      ADDR_STATUS: rd_mux = {30'd0, underflow, ctrl_en};
      default:     rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (rst) begin
      ready_en  <= 1'b0;
      ctrl_en   <= 1'b0;
      fbaddr    <= 32'd0;
      underflow <= 1'b0;
      bvalid_r  <= 1'b0;
      rvalid_r  <= 1'b0;
      rdata_r   <= 32'd0;
    end else begin
      ready_en <= 1'b1;
      if (wr_fire) begin
        if (s00_axi_awaddr == ADDR_CTRL)
          ctrl_en <= s00_axi_wdata[0];
        if (s00_axi_awaddr == ADDR_FBADDR)
          fbaddr <= {s00_axi_wdata[31:6], 6'd0};
      end
      // A fresh underflow wins over a simultaneous write-1-to-clear.
      if (uf_set)
        underflow <= 1'b1;
      else if (wr_fire && s00_axi_awaddr == ADDR_STATUS && s00_axi_wdata[1])
        underflow <= 1'b0;
      if (wr_fire)
        bvalid_r <= 1'b1;
      else if (s00_axi_bready)
        bvalid_r <= 1'b0;
      if (rd_fire) begin
        rvalid_r <= 1'b1;
        rdata_r  <= rd_mux;
      end else if (s00_axi_rready) begin
        rvalid_r <= 1'b0;
      end
    end
  end

  assign strobe    = ctrl_en && (div == 2'd2);
  assign active    = (h >= H_ACT_START) && (h < H_ACT_END) &&
                     (v >= V_ACT_START) && (v < V_ACT_END);
  assign frame_end = strobe && (h == H_LAST) && (v == V_LAST);

  always_ff @(posedge s00_axi_aclk) begin
    if (rst || !ctrl_en) begin
      div <= 2'd0;
      h   <= 10'd0;
      v   <= 9'd0;
    end else begin
      div <= strobe ? 2'd0 : div + 2'd1;
      if (strobe) begin
        if (h == H_LAST) begin
          h <= 10'd0;
          v <= (v == V_LAST) ? 9'd0 : v + 9'd1;
        end else begin
          h <= h + 10'd1;
        end
      end
    end
  end

  assign pop    = strobe && active && (count != '0);
  assign uf_set = strobe && active && (count == '0);

  always_ff @(posedge s00_axi_aclk) begin
    if (rst || !ctrl_en) begin
      LCD_DEN   <= 1'b0;
      LCD_HSYNC <= 1'b1;
      LCD_VSYNC <= 1'b1;
      LCD_DATA  <= 24'd0;
    end else if (strobe) begin
      LCD_DEN   <= active;
      LCD_HSYNC <= !(h < H_SYNC_END);
      LCD_VSYNC <= !(v < V_SYNC_END);
      LCD_DATA  <= pop ? mem[rd_ptr] : 24'd0;
    end
  end

  // Beats arriving while disabled are accepted but dropped; the FIFO stays flushed.
  assign beat = (state == F_RECV) && m00_axi_rvalid;
  assign push = beat && ctrl_en && (count != CW'(FIFO_DEPTH));

  always_ff @(posedge s00_axi_aclk) begin
    if (push)
      mem[wr_ptr] <= m00_axi_rdata[23:0];
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (rst || !ctrl_en) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign en_rise = ctrl_en && !en_d;
  assign issue   = (state == F_IDLE) && ctrl_en && en_d && !frame_end &&
                   (count <= CW'(FIFO_DEPTH - C_M00_AXI_BURST_LEN)) &&
                   (words < WW'(FRAME_WORDS));

  always_ff @(posedge s00_axi_aclk) begin
    if (rst) begin
      state      <= F_IDLE;
      en_d       <= 1'b0;
      ar_addr    <= 32'd0;
      fetch_addr <= 32'd0;
      words      <= '0;
    end else begin
      en_d <= ctrl_en;
      case (state)
        F_IDLE: if (issue) begin
          state   <= F_AR;
          ar_addr <= fetch_addr;
        end
        F_AR:   if (m00_axi_arready) state <= F_RECV;
        F_RECV: if (m00_axi_rvalid && m00_axi_rlast) state <= F_IDLE;
        default: state <= F_IDLE;
      endcase
      if (en_rise || frame_end) begin
        fetch_addr <= fbaddr;
        words      <= '0;
      end else if (state == F_AR && m00_axi_arready) begin
        fetch_addr <= fetch_addr + 32'(C_M00_AXI_BURST_LEN * 4);
        words      <= words + WW'(C_M00_AXI_BURST_LEN);
      end
    end
  end

  assign m00_axi_araddr  = ar_addr;
  assign m00_axi_arlen   = 8'(C_M00_AXI_BURST_LEN - 1);
  assign m00_axi_arvalid = (state == F_AR);
  assign m00_axi_rready  = (state == F_RECV);

endmodule

// File: tb/tb_gslcd.sv
// tb/tb_gslcd.sv - directed self-checking bench for gslcd
module tb_gslcd;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic        m_rvalid;
  logic        m_rlast;
  logic        m_rready;
  logic        den;
  logic        hsync;
  logic        vsync;
  logic [23:0] lcd_data;

  int checks = 0;
  int failures = 0;

  logic        auto_resp = 1'b0;
  int          resp_state = 0;
  int          resp_beat = 0;
  logic [31:0] resp_addr = 32'd0;

  always #5 clk = ~clk;

  gslcd dut (
    .s00_axi_aclk(clk), .s00_axi_areset(rst),
    .s00_axi_awaddr(awaddr), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .m00_axi_araddr(m_araddr), .m00_axi_arlen(m_arlen), .m00_axi_arvalid(m_arvalid),
    .m00_axi_arready(m_arready), .m00_axi_rdata(m_rdata), .m00_axi_rvalid(m_rvalid),
    .m00_axi_rlast(m_rlast), .m00_axi_rready(m_rready),
    .LCD_DEN(den), .LCD_HSYNC(hsync), .LCD_VSYNC(vsync), .LCD_DATA(lcd_data)
  );

  // One clock; optionally runs a memory model returning {0xA5, word index} per beat.
  task automatic step();
    @(posedge clk);
    #1;
    if (auto_resp) begin
      case (resp_state)
        0: if (m_arvalid) begin
          m_arready = 1'b1;
          resp_addr = m_araddr;
          resp_state = 1;
        end
        1: begin
          m_arready = 1'b0;
          resp_beat = 0;
          m_rvalid = 1'b1;
          m_rdata = {8'hA5, 24'(resp_addr >> 2)};
          m_rlast = 1'b0;
          resp_state = 2;
        end
        default: begin
          if (resp_beat == 15) begin
            m_rvalid = 1'b0;
            m_rlast = 1'b0;
            resp_state = 0;
          end else begin
            resp_beat++;
            m_rdata = {8'hA5, 24'((resp_addr >> 2) + 32'(resp_beat))};
            m_rlast = (resp_beat == 15);
          end
        end
      endcase
    end
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, output int blat);
    int n;
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    n = 0;
    while (!(awready && wready) && n < 20) begin step(); n++; end
    checks++;
    if (!(awready && wready)) begin
      failures++;
      $display("FAIL axi_write_handshake addr=%0h awready=%0b wready=%0b required 1", a, awready, wready);
    end
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    blat = 1;
    while (!bvalid && blat < 5) begin step(); blat++; end
    bready = 1'b1;
    step();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int n;
    araddr = a; arvalid = 1'b1;
    #1;
    n = 0;
    while (!arready && n < 20) begin step(); n++; end
    step();
    arvalid = 1'b0;
    checks++;
    if (!rvalid) begin
      failures++;
      $display("FAIL axi_read_rvalid addr=%0h rvalid=%0b required 1 one cycle after AR", a, rvalid);
    end
    d = rdata;
    rready = 1'b1;
    step();
    rready = 1'b0;
  endtask

  task automatic wait_arvalid(input int limit);
    int n;
    n = 0;
    while (!m_arvalid && n < limit) begin step(); n++; end
  endtask

  task automatic feed_beats(input int first, input int cnt, input bit last, output bit ok);
    ok = 1'b1;
    for (int i = 0; i < cnt; i++) begin
      m_rvalid = 1'b1;
      m_rdata = 32'(first + i);
      m_rlast = last && (i == cnt - 1);
      #1;
      if (!m_rready) ok = 1'b0;
      step();
    end
    m_rvalid = 1'b0;
    m_rlast = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    repeat (3) step();
    checks++;
    if ({awready, wready, arready, bvalid, rvalid, m_arvalid, m_rready} !== 7'b0) begin
      failures++;
      $display("FAIL reset_handshakes got=%b required 0000000",
               {awready, wready, arready, bvalid, rvalid, m_arvalid, m_rready});
    end
    checks++;
    if ({den, hsync, vsync} !== 3'b011 || lcd_data !== 24'd0) begin
      failures++;
      $display("FAIL reset_lcd den/hs/vs=%b data=%h required 011 000000", {den, hsync, vsync}, lcd_data);
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    rst = 1'b0;
    step();
    axi_read(4'h0, d);
    checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL reset_ctrl got=%h required 0", d); end
    axi_read(4'h8, d);
    checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL reset_status got=%h required 0", d); end
  endtask

  task automatic test_regs();
    logic [31:0] d;
    int lat;
    axi_write(4'h4, 32'h1234567F, lat);
    axi_read(4'h4, d);
    checks++;
    if (d !== 32'h12345640) begin failures++; $display("FAIL regs_fbaddr got=%h required 12345640", d); end
    axi_write(4'hC, 32'hFFFFFFFF, lat);
    axi_read(4'hC, d);
    checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL regs_unmapped got=%h required 0", d); end
    axi_write(4'h8, 32'h1, lat);
    axi_read(4'h8, d);
    checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL regs_status_ro got=%h required 0", d); end
  endtask

  task automatic test_fetch();
    int lat;
    bit ok;
    bit seen;
    axi_write(4'h4, 32'h0, lat);
    axi_write(4'h0, 32'h1, lat);
    checks++;
    if (lat > 2) begin failures++; $display("FAIL fetch_bvalid_latency got=%0d required <=2", lat); end
    wait_arvalid(20);
    checks++;
    if (m_arvalid !== 1'b1 || m_araddr !== 32'h0 || m_arlen !== 8'd15) begin
      failures++;
      $display("FAIL fetch_first_ar arvalid=%b araddr=%h arlen=%0d required 1 0 15", m_arvalid, m_araddr, m_arlen);
    end
    m_arready = 1'b1; step(); m_arready = 1'b0;
    feed_beats(0, 16, 1'b1, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL fetch_rready_burst1 rready dropped mid-burst, required 1"); end
    checks++;
    if (m_rready !== 1'b0) begin failures++; $display("FAIL fetch_rready_after_rlast got=%b required 0", m_rready); end
    wait_arvalid(20);
    checks++;
    if (m_arvalid !== 1'b1 || m_araddr !== 32'h40) begin
      failures++;
      $display("FAIL fetch_second_ar arvalid=%b araddr=%h required 1 00000040", m_arvalid, m_araddr);
    end
    m_arready = 1'b1; step(); m_arready = 1'b0;
    feed_beats(16, 16, 1'b1, ok);
    seen = 1'b0;
    repeat (30) begin step(); if (m_arvalid) seen = 1'b1; end
    checks++;
    if (seen) begin failures++; $display("FAIL fetch_fifo_full_no_ar arvalid=1 seen, required 0 with FIFO full"); end
  endtask

  task automatic test_disable_mid_burst();
    int lat;
    bit ok;
    bit seen;
    axi_write(4'h0, 32'h0, lat);
    axi_write(4'h4, 32'h100, lat);
    axi_write(4'h0, 32'h1, lat);
    wait_arvalid(20);
    checks++;
    if (m_arvalid !== 1'b1 || m_araddr !== 32'h100) begin
      failures++;
      $display("FAIL disable_ar_addr arvalid=%b araddr=%h required 1 00000100", m_arvalid, m_araddr);
    end
    m_arready = 1'b1; step(); m_arready = 1'b0;
    feed_beats(0, 4, 1'b0, ok);
    axi_write(4'h0, 32'h0, lat);
    checks++;
    if (m_rready !== 1'b1) begin failures++; $display("FAIL disable_rready_held got=%b required 1", m_rready); end
    feed_beats(4, 12, 1'b1, ok);
    checks++;
    if (!ok || m_rready !== 1'b0) begin
      failures++;
      $display("FAIL disable_drain ok=%b rready=%b required 1 0", ok, m_rready);
    end
    seen = 1'b0;
    repeat (20) begin step(); if (m_arvalid) seen = 1'b1; end
    checks++;
    if (seen || {den, hsync, vsync} !== 3'b011 || lcd_data !== 24'd0) begin
      failures++;
      $display("FAIL disable_idle ar_seen=%b den/hs/vs=%b data=%h required 0 011 000000", seen, {den, hsync, vsync}, lcd_data);
    end
  endtask

  task automatic test_timing_and_pixels();
    int n;
    int vcnt;
    int hrun;
    bit hdone;
    bit bad_idle;
    int lat;
    axi_write(4'h4, 32'h0, lat);
    auto_resp = 1'b1;
    resp_state = 0;
    bready = 1'b1;
    awaddr = 4'h0; wdata = 32'h1; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    n = 0;
    while (!(awready && wready) && n < 20) begin step(); n++; end
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (vsync && n < 20) begin step(); n++; end
    bready = 1'b0;
    checks++;
    if (vsync !== 1'b0 || hsync !== 1'b0) begin
      failures++;
      $display("FAIL timing_start vsync=%b hsync=%b required 0 0 shortly after enable", vsync, hsync);
    end
    vcnt = 1; hrun = 1; hdone = 1'b0;
    while (!vsync && vcnt < 20000) begin
      step();
      if (!vsync) vcnt++;
      if (!hsync) begin if (!hdone) hrun++; end
      else hdone = 1'b1;
    end
    checks++;
    if (hrun != 123) begin failures++; $display("FAIL timing_hsync_low got=%0d clocks required 123", hrun); end
    checks++;
    if (vcnt != 15750) begin failures++; $display("FAIL timing_vsync_low got=%0d clocks required 15750", vcnt); end
    n = 0; bad_idle = 1'b0;
    while (!den && n < 5000) begin
      step(); n++;
      if (!den && lcd_data !== 24'd0) bad_idle = 1'b1;
    end
    checks++;
    if (n != 3279) begin failures++; $display("FAIL pixel_first_den got=%0d clocks after vsync rise required 3279", n); end
    checks++;
    if (bad_idle) begin failures++; $display("FAIL pixel_blank_data nonzero data seen with den=0, required 0"); end
    checks++;
    if (den !== 1'b1 || lcd_data !== 24'h000000) begin
      failures++;
      $display("FAIL pixel_0 den=%b data=%h required 1 000000", den, lcd_data);
    end
    step();
    checks++;
    if (lcd_data !== 24'h000000) begin failures++; $display("FAIL pixel_hold data=%h required 000000 between strobes", lcd_data); end
    step(); step();
    checks++;
    if (den !== 1'b1 || lcd_data !== 24'h000001) begin
      failures++;
      $display("FAIL pixel_1 den=%b data=%h required 1 000001", den, lcd_data);
    end
    repeat (3) step();
    checks++;
    if (lcd_data !== 24'h000002) begin failures++; $display("FAIL pixel_2 data=%h required 000002", lcd_data); end
  endtask

  task automatic test_underflow();
    int n;
    int lat;
    logic [31:0] d;
    axi_write(4'h0, 32'h0, lat);
    repeat (40) step();
    auto_resp = 1'b0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
    axi_write(4'h0, 32'h1, lat);
    wait_arvalid(20);
    m_arready = 1'b1; step(); m_arready = 1'b0;
    n = 0;
    while (!den && n < 25000) begin step(); n++; end
    checks++;
    if (den !== 1'b1 || lcd_data !== 24'd0) begin
      failures++;
      $display("FAIL underflow_pixel den=%b data=%h required 1 000000", den, lcd_data);
    end
    axi_read(4'h8, d);
    checks++;
    if (d !== 32'h3) begin failures++; $display("FAIL underflow_status got=%h required 3", d); end
    n = 0;
    while (den && n < 2000) begin step(); n++; end
    axi_write(4'h8, 32'h2, lat);
    axi_read(4'h8, d);
    checks++;
    if (d !== 32'h1) begin failures++; $display("FAIL underflow_clear got=%h required 1", d); end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    bit seen;
    logic [31:0] d;
    checks++;
    if (m_rready !== 1'b1) begin failures++; $display("FAIL rstburst_outstanding rready=%b required 1", m_rready); end
    feed_beats(0, 3, 1'b0, ok);
    m_rvalid = 1'b1;
    rst = 1'b1;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    step();
    checks++;
    if ({awready, wready, arready, bvalid, rvalid, m_arvalid, m_rready, den, hsync, vsync} !== 10'b0000000011
        || lcd_data !== 24'd0) begin
      failures++;
      $display("FAIL rstburst_outputs got=%b data=%h required 0000000011 000000",
               {awready, wready, arready, bvalid, rvalid, m_arvalid, m_rready, den, hsync, vsync}, lcd_data);
    end
    rst = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; m_rvalid = 1'b0;
    seen = 1'b0;
    repeat (10) begin step(); if (m_arvalid || m_rready) seen = 1'b1; end
    checks++;
    if (seen) begin failures++; $display("FAIL rstburst_fetch_idle arvalid/rready seen, required 0"); end
    axi_read(4'h8, d);
    checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL rstburst_status got=%h required 0", d); end
  endtask

  initial begin
    rst = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    m_arready = 1'b0; m_rdata = '0; m_rvalid = 1'b0; m_rlast = 1'b0;
    test_reset();
    test_regs();
    test_fetch();
    test_disable_mid_burst();
    test_timing_and_pixels();
    test_underflow();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
